// File: rtl/ram_fifo_ctrl.sv
// 128-deep, 8-bit FIFO controller driving an external dual-port RAM
// (port 1 write-only, port 2 read-only with one cycle of registered read latency).
module ram_fifo_ctrl #(
  parameter int unsigned AF_LEVEL = 120,
  parameter int unsigned AE_LEVEL = 8
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic [7:0] count,
  output logic       ovf,
  output logic       unf,
  input  logic       clr_err,
  output logic [6:0] a1,
  output logic [7:0] d1,
  output logic       we1,
  output logic [6:0] a2,
  output logic [7:0] d2,
  output logic       we2,
  input  logic [7:0] q2
);

  localparam logic [7:0] DEPTH  = 8'd128;
  localparam logic [7:0] AF_LVL = 8'(AF_LEVEL);
  localparam logic [7:0] AE_LVL = 8'(AE_LEVEL);

  logic [6:0] wr_ptr;
  logic [6:0] rd_ptr;
  logic       push_ok;
  logic       pop_ok;

  always_comb begin
    full         = (count == DEPTH);
    empty        = (count == '0);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
    push_ok      = wr_en && !full;
    pop_ok       = rd_en && !empty;
  end

  // RAM port wiring; we1 is gated by rst_n so an asynchronous reset blocks writes at once.
  always_comb begin
    a1      = wr_ptr;
    d1      = wr_data;
    we1     = push_ok && rst_n;
    a2      = rd_ptr;
    d2      = '0;
    we2     = 1'b0;
    rd_data = q2;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 7'd1;
      if (pop_ok)  rd_ptr <= rd_ptr + 7'd1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
      rd_valid <= pop_ok;
      // A new error on the same edge as clr_err takes priority over the clear.
      ovf <= (ovf && !clr_err) || (wr_en && full);
      unf <= (unf && !clr_err) || (rd_en && empty);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural dual-port RAM, reference occupancy model
// and a data scoreboard queue filled on accepted pushes and drained on rd_valid.
module tb_ram_fifo_ctrl;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data, count, d1, d2, q2;
  logic       rd_valid, full, empty, almost_full, almost_empty, ovf, unf;
  logic [6:0] a1, a2;
  logic       we1, we2;

  logic [7:0] ram [128];

  int         checks = 0;
  int         errors = 0;
  int         mcount = 0;
  logic [6:0] mwr = '0;
  logic [6:0] mrd = '0;
  logic       mov = 1'b0;
  logic       mun = 1'b0;
  logic [7:0] sb [$];

  ram_fifo_ctrl #(.AF_LEVEL(120), .AE_LEVEL(8)) dut (
    .clk1(clk1), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .ovf(ovf), .unf(unf), .clr_err(clr_err), .a1(a1), .d1(d1), .we1(we1),
    .a2(a2), .d2(d2), .we2(we2), .q2(q2)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (we1) ram[a1] <= d1;
    q2 <= ram[a2];
  end

  // One clock of stimulus: checks RAM-port drive before the edge, then the
  // scoreboard, occupancy and flags after it.
  task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic clr);
    logic       push, pop;
    logic [7:0] exp;
    wr_en = w; wr_data = wd; rd_en = r; clr_err = clr;
    push = w && (mcount != 128);
    pop  = r && (mcount != 0);
    #1;
    checks++;
    if (we1 !== push || a1 !== mwr || d1 !== wd || a2 !== mrd || we2 !== 1'b0 || d2 !== 8'h00) begin
      errors++;
      $display("FAIL ram_port: we1=%b a1=%0d d1=%h a2=%0d we2=%b d2=%h required we1=%b a1=%0d d1=%h a2=%0d we2=0 d2=00",
               we1, a1, d1, a2, we2, d2, push, mwr, wd, mrd);
    end
    if (push) sb.push_back(wd);
    mov = (mov && !clr) || (w && mcount == 128);
    mun = (mun && !clr) || (r && mcount == 0);
    mcount = mcount + int'(push) - int'(pop);
    mwr = mwr + 7'(push);
    mrd = mrd + 7'(pop);
    @(posedge clk1); #1;
    checks++;
    if (rd_valid !== pop) begin
      errors++;
      $display("FAIL rd_valid: got %b required %b", rd_valid, pop);
    end
    if (pop) begin
      exp = sb.pop_front();
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL rd_data: got %h required %h", rd_data, exp);
      end
    end
    checks++;
    if (count !== 8'(mcount)) begin
      errors++;
      $display("FAIL count: got %0d required %0d", count, mcount);
    end
    checks++;
    if (full !== (mcount == 128) || empty !== (mcount == 0) ||
        almost_full !== (mcount >= 120) || almost_empty !== (mcount <= 8)) begin
      errors++;
      $display("FAIL flags: got full=%b empty=%b af=%b ae=%b at count %0d", full, empty, almost_full, almost_empty, mcount);
    end
    checks++;
    if (ovf !== mov || unf !== mun) begin
      errors++;
      $display("FAIL err_flags: got ovf=%b unf=%b required ovf=%b unf=%b", ovf, unf, mov, mun);
    end
  endtask

  task automatic model_reset();
    mcount = 0; mwr = '0; mrd = '0; mov = 1'b0; mun = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h55;
    #2;
    checks++;
    if (count !== 8'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
        almost_full !== 1'b0 || rd_valid !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0 || we1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b ae=%b full=%b af=%b rd_valid=%b ovf=%b unf=%b we1=%b",
               count, empty, almost_empty, full, almost_full, rd_valid, ovf, unf, we1);
    end
    wr_en = 1'b0;
    model_reset();
    @(negedge clk1); rst_n = 1'b1;
    @(posedge clk1); #1;
    checks++;
    if (rd_valid !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: rd_valid=%b count=%0d required 0 and 0", rd_valid, count);
    end
  endtask

  task automatic test_basic();
    step(1, 8'hCC, 0, 0);
    step(1, 8'hCD, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_empty: got %b required 1", empty);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 128; i++) step(1, 8'(i), 0, 0);
    checks++;
    if (full !== 1'b1 || count !== 8'd128) begin
      errors++;
      $display("FAIL full_reached: full=%b count=%0d required 1 and 128", full, count);
    end
    step(1, 8'hEE, 0, 0);
    checks++;
    if (ovf !== 1'b1 || count !== 8'd128) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d required 1 and 128", ovf, count);
    end
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 128; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
  endtask

  task automatic test_levels();
    for (int i = 0; i < 119; i++) step(1, 8'($urandom_range(255)), 0, 0);
    step(1, 8'h5A, 0, 0);
    checks++;
    if (almost_full !== 1'b1 || count !== 8'd120) begin
      errors++;
      $display("FAIL almost_full_120: af=%b count=%0d required 1 and 120", almost_full, count);
    end
    for (int i = 0; i < 111; i++) step(0, 8'h00, 1, 0);
    checks++;
    if (almost_empty !== 1'b0 || count !== 8'd9) begin
      errors++;
      $display("FAIL almost_empty_9: ae=%b count=%0d required 0 and 9", almost_empty, count);
    end
    step(0, 8'h00, 1, 0);
    checks++;
    if (almost_empty !== 1'b1 || count !== 8'd8) begin
      errors++;
      $display("FAIL almost_empty_8: ae=%b count=%0d required 1 and 8", almost_empty, count);
    end
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
  endtask

  task automatic test_wrap();
    int wraps = 0;
    for (int i = 0; i < 5; i++) step(1, 8'($urandom_range(255)), 0, 0);
    for (int i = 0; i < 195; i++) begin
      if (mwr == 7'd127) wraps++;
      step(1, 8'($urandom_range(255)), ($urandom_range(3) != 0) || (mcount > 6), 0);
    end
    while (mcount > 0) step(0, 8'h00, 1, 0);
    checks++;
    if (wraps == 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap: pointer wraps=%0d empty=%b required >0 and 1", wraps, empty);
    end
  endtask

  task automatic test_simultaneous();
    step(1, 8'hA1, 1, 0);
    checks++;
    if (unf !== 1'b1 || count !== 8'd1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: unf=%b count=%0d rd_valid=%b required 1 1 0", unf, count, rd_valid);
    end
    for (int i = 0; i < 127; i++) step(1, 8'(i + 3), 0, 0);
    step(1, 8'hB2, 1, 0);
    checks++;
    if (ovf !== 1'b1 || count !== 8'd127) begin
      errors++;
      $display("FAIL simul_full: ovf=%b count=%0d required 1 and 127", ovf, count);
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if (ovf !== 1'b0 || unf !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: ovf=%b unf=%b required 0 0", ovf, unf);
    end
    while (mcount > 0) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 1);
    checks++;
    if (unf !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_error: unf=%b required 1", unf);
    end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 51; i++) step(1, 8'($urandom_range(255)), 0, 0);
    step(0, 8'h00, 1, 0);
    rst_n = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    checks++;
    if (count !== 8'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || we1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d empty=%b rd_valid=%b we1=%b required 0 1 0 0", count, empty, rd_valid, we1);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    @(negedge clk1); rst_n = 1'b1;
    @(posedge clk1); #1;
    checks++;
    if (rd_valid !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_release: rd_valid=%b count=%0d required 0 0", rd_valid, count);
    end
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_levels();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
